// File: rtl/elastic_pipe_chain.sv
// Parametrised elastic pipeline register chain: per-stage valid bits, valid/ready handshake,
// bubble collapsing, global hold and partial flush of the youngest stages.
module elastic_pipe_chain #(
    parameter int DATA_W = 32,
    parameter int STAGES = 4,
    localparam int CNT_W = $clog2(STAGES + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    input  logic              hold,
    input  logic              flush,
    input  logic [CNT_W-1:0]  flush_depth,
    output logic [CNT_W-1:0]  occupancy,
    output logic [31:0]       retired
);

    logic [STAGES-1:0] valid_q;
    logic [STAGES-1:0] valid_n;
    logic [STAGES-1:0] rdy;
    logic [DATA_W-1:0] data_q [STAGES];
    logic [DATA_W-1:0] data_n [STAGES];
    logic [CNT_W-1:0]  kill_k;
    logic [CNT_W-1:0]  occ_q;
    logic [CNT_W-1:0]  occ_n;
    logic [31:0]       retired_q;
    logic              advance;
    logic              full_kill;
    logic              in_fire;
    logic              out_fire;

    // Ready ripples from the output stage back to the input; an empty stage is always ready.
    always_comb begin
        logic chain;
        rdy = '0;
        chain = !valid_q[STAGES-1] | out_ready;
        rdy[STAGES-1] = chain;
        for (int s = STAGES - 2; s >= 0; s--) begin
            chain = !valid_q[s] | chain;
            rdy[s] = chain;
        end
    end

    always_comb begin
        kill_k = '0;
        if (flush) begin
            kill_k = (flush_depth > CNT_W'(STAGES)) ? CNT_W'(STAGES) : flush_depth;
        end
    end

    assign advance   = !hold;
    assign full_kill = flush && (kill_k == CNT_W'(STAGES));
    assign out_valid = valid_q[STAGES-1] & advance & !full_kill;
    assign out_data  = data_q[STAGES-1];
    assign in_ready  = !rst & rdy[0] & advance & !flush;
    assign in_fire   = in_valid & in_ready;
    assign out_fire  = out_valid & out_ready;
    assign occupancy = occ_q;
    assign retired   = retired_q;

    // Killed stages go invalid; stage K takes a bubble instead of its killed predecessor.
    always_comb begin
        valid_n = valid_q;
        for (int s = 0; s < STAGES; s++) begin
            data_n[s] = data_q[s];
        end
        if (kill_k != '0) begin
            valid_n[0] = 1'b0;
        end else if (advance && rdy[0]) begin
            valid_n[0] = in_fire;
            if (in_fire) begin
                data_n[0] = in_data;
            end
        end
        for (int s = 1; s < STAGES; s++) begin
            if (CNT_W'(s) < kill_k) begin
                valid_n[s] = 1'b0;
            end else if (advance && rdy[s]) begin
                if (flush && CNT_W'(s) == kill_k) begin
                    valid_n[s] = 1'b0;
                end else begin
                    valid_n[s] = valid_q[s-1];
                    if (valid_q[s-1]) begin
                        data_n[s] = data_q[s-1];
                    end
                end
            end
        end
    end

    always_comb begin
        occ_n = '0;
        for (int s = 0; s < STAGES; s++) begin
            occ_n = occ_n + CNT_W'(valid_n[s]);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q   <= '0;
            occ_q     <= '0;
            retired_q <= '0;
            for (int s = 0; s < STAGES; s++) begin
                data_q[s] <= '0;
            end
        end else begin
            valid_q   <= valid_n;
            occ_q     <= occ_n;
            retired_q <= retired_q + 32'(out_fire);
            for (int s = 0; s < STAGES; s++) begin
                data_q[s] <= data_n[s];
            end
        end
    end

endmodule

// File: tb/tb_elastic_pipe_chain.sv
// Directed testbench for elastic_pipe_chain (DATA_W=32, STAGES=4) with hand-computed expectations.
module tb_elastic_pipe_chain;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_data;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic        hold;
    logic        flush;
    logic [2:0]  flush_depth;
    logic [2:0]  occupancy;
    logic [31:0] retired;

    int checks = 0;
    int failures = 0;

    elastic_pipe_chain #(.DATA_W(32), .STAGES(4)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .hold(hold), .flush(flush), .flush_depth(flush_depth),
        .occupancy(occupancy), .retired(retired)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
        hold = 1'b0; flush = 1'b0; flush_depth = '0;
        step(); step();
        checks++; if (out_valid !== 1'b0) begin failures++; $display("[TB] FAIL reset_out_valid got %b want 0", out_valid); end
        checks++; if (in_ready !== 1'b0) begin failures++; $display("[TB] FAIL reset_in_ready got %b want 0", in_ready); end
        checks++; if (occupancy !== 3'd0) begin failures++; $display("[TB] FAIL reset_occupancy got %0d want 0", occupancy); end
        checks++; if (retired !== 32'd0) begin failures++; $display("[TB] FAIL reset_retired got %0d want 0", retired); end
        rst = 1'b0;
        #1;
        checks++; if (in_ready !== 1'b1) begin failures++; $display("[TB] FAIL release_in_ready got %b want 1", in_ready); end
    endtask

    task automatic test_stream();
        out_ready = 1'b1; in_valid = 1'b1; in_data = 32'h1;
        step();
        in_data = 32'h2; step();
        in_data = 32'h3; step();
        in_valid = 1'b0;
        checks++; if (out_valid !== 1'b0) begin failures++; $display("[TB] FAIL stream_early_valid got %b want 0", out_valid); end
        step();
        checks++; if (out_valid !== 1'b1 || out_data !== 32'h1) begin failures++; $display("[TB] FAIL stream_beat1 got v=%b d=%h want v=1 d=1", out_valid, out_data); end
        step();
        checks++; if (out_valid !== 1'b1 || out_data !== 32'h2) begin failures++; $display("[TB] FAIL stream_beat2 got v=%b d=%h want v=1 d=2", out_valid, out_data); end
        step();
        checks++; if (out_valid !== 1'b1 || out_data !== 32'h3) begin failures++; $display("[TB] FAIL stream_beat3 got v=%b d=%h want v=1 d=3", out_valid, out_data); end
        step();
        checks++; if (retired !== 32'd3) begin failures++; $display("[TB] FAIL stream_retired got %0d want 3", retired); end
        checks++; if (occupancy !== 3'd0) begin failures++; $display("[TB] FAIL stream_occupancy got %0d want 0", occupancy); end
    endtask

    task automatic test_full_throughput();
        out_ready = 1'b0; in_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            in_data = 32'h10 + 32'(i);
            step();
        end
        checks++; if (occupancy !== 3'd4) begin failures++; $display("[TB] FAIL full_occupancy got %0d want 4", occupancy); end
        checks++; if (in_ready !== 1'b0) begin failures++; $display("[TB] FAIL full_in_ready got %b want 0", in_ready); end
        in_data = 32'h14; out_ready = 1'b1;
        #1;
        checks++; if (in_ready !== 1'b1 || out_data !== 32'h10) begin failures++; $display("[TB] FAIL full_shift_ready got r=%b d=%h want r=1 d=10", in_ready, out_data); end
        step();
        in_valid = 1'b0;
        checks++; if (occupancy !== 3'd4 || out_data !== 32'h11) begin failures++; $display("[TB] FAIL full_shift got occ=%0d d=%h want occ=4 d=11", occupancy, out_data); end
        checks++; if (retired !== 32'd4) begin failures++; $display("[TB] FAIL full_shift_retired got %0d want 4", retired); end
        for (int i = 0; i < 4; i++) step();
        checks++; if (occupancy !== 3'd0 || retired !== 32'd8) begin failures++; $display("[TB] FAIL full_drain got occ=%0d ret=%0d want occ=0 ret=8", occupancy, retired); end
    endtask

    task automatic test_bubble_collapse();
        out_ready = 1'b0;
        in_valid = 1'b1; in_data = 32'hA1; step();
        in_valid = 1'b0; step();
        in_valid = 1'b1; in_data = 32'hB2; step();
        in_valid = 1'b0;
        for (int i = 0; i < 3; i++) step();
        checks++; if (dut.valid_q !== 4'b1100) begin failures++; $display("[TB] FAIL bubble_valid got %b want 1100", dut.valid_q); end
        checks++; if (occupancy !== 3'd2 || in_ready !== 1'b1) begin failures++; $display("[TB] FAIL bubble_occ got occ=%0d r=%b want occ=2 r=1", occupancy, in_ready); end
        checks++; if (out_valid !== 1'b1 || out_data !== 32'hA1 || dut.data_q[2] !== 32'hB2) begin failures++; $display("[TB] FAIL bubble_data got v=%b d=%h s2=%h want v=1 d=a1 s2=b2", out_valid, out_data, dut.data_q[2]); end
        out_ready = 1'b1; step();
        checks++; if (out_valid !== 1'b1 || out_data !== 32'hB2) begin failures++; $display("[TB] FAIL bubble_second got v=%b d=%h want v=1 d=b2", out_valid, out_data); end
        step();
        checks++; if (occupancy !== 3'd0 || retired !== 32'd10) begin failures++; $display("[TB] FAIL bubble_drain got occ=%0d ret=%0d want occ=0 ret=10", occupancy, retired); end
    endtask

    task automatic test_flush();
        out_ready = 1'b0; in_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            in_data = 32'hA + 32'(i);
            step();
        end
        in_data = 32'hE; flush = 1'b1; flush_depth = 3'd2;
        #1;
        checks++; if (in_ready !== 1'b0) begin failures++; $display("[TB] FAIL flush_in_ready got %b want 0", in_ready); end
        step();
        flush = 1'b0; in_valid = 1'b0;
        checks++; if (occupancy !== 3'd2 || dut.valid_q !== 4'b1100) begin failures++; $display("[TB] FAIL flush2_state got occ=%0d v=%b want occ=2 v=1100", occupancy, dut.valid_q); end
        checks++; if (out_data !== 32'hA) begin failures++; $display("[TB] FAIL flush2_head got %h want a", out_data); end
        out_ready = 1'b1; step();
        checks++; if (out_valid !== 1'b1 || out_data !== 32'hB) begin failures++; $display("[TB] FAIL flush2_second got v=%b d=%h want v=1 d=b", out_valid, out_data); end
        step();
        checks++; if (out_valid !== 1'b0 || occupancy !== 3'd0 || retired !== 32'd12) begin failures++; $display("[TB] FAIL flush2_end got v=%b occ=%0d ret=%0d want v=0 occ=0 ret=12", out_valid, occupancy, retired); end
        out_ready = 1'b0; in_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            in_data = 32'hA + 32'(i);
            step();
        end
        in_valid = 1'b0; out_ready = 1'b1; flush = 1'b1; flush_depth = 3'd7;
        #1;
        checks++; if (out_valid !== 1'b0) begin failures++; $display("[TB] FAIL flush7_out_valid got %b want 0", out_valid); end
        step();
        flush = 1'b0;
        checks++; if (occupancy !== 3'd0 || retired !== 32'd12) begin failures++; $display("[TB] FAIL flush7_state got occ=%0d ret=%0d want occ=0 ret=12", occupancy, retired); end
    endtask

    task automatic test_hold();
        logic [31:0] seen [4];
        int n;
        out_ready = 1'b1; in_valid = 1'b1;
        in_data = 32'h51; step();
        in_data = 32'h52; step();
        in_data = 32'h53; hold = 1'b1;
        #1;
        checks++; if (in_ready !== 1'b0 || out_valid !== 1'b0) begin failures++; $display("[TB] FAIL hold_handshake got r=%b v=%b want r=0 v=0", in_ready, out_valid); end
        for (int i = 0; i < 3; i++) step();
        checks++; if (dut.valid_q !== 4'b0011 || dut.data_q[1] !== 32'h51 || occupancy !== 3'd2) begin failures++; $display("[TB] FAIL hold_frozen got v=%b s1=%h occ=%0d want v=0011 s1=51 occ=2", dut.valid_q, dut.data_q[1], occupancy); end
        hold = 1'b0; step();
        in_valid = 1'b0;
        n = 0;
        for (int i = 0; i < 6; i++) begin
            step();
            if (out_valid === 1'b1 && n < 4) begin seen[n] = out_data; n++; end
        end
        checks++; if (n !== 3) begin failures++; $display("[TB] FAIL hold_resume_count got %0d want 3", n); end
        checks++; if (n >= 3 && (seen[0] !== 32'h51 || seen[1] !== 32'h52 || seen[2] !== 32'h53)) begin failures++; $display("[TB] FAIL hold_resume_order got %h %h %h want 51 52 53", seen[0], seen[1], seen[2]); end
        in_valid = 1'b1;
        in_data = 32'h61; step();
        in_data = 32'h62; step();
        in_valid = 1'b0; hold = 1'b1; flush = 1'b1; flush_depth = 3'd1;
        #1;
        checks++; if (in_ready !== 1'b0) begin failures++; $display("[TB] FAIL holdflush_in_ready got %b want 0", in_ready); end
        step();
        hold = 1'b0; flush = 1'b0;
        checks++; if (dut.valid_q !== 4'b0010 || occupancy !== 3'd1) begin failures++; $display("[TB] FAIL holdflush_state got v=%b occ=%0d want v=0010 occ=1", dut.valid_q, occupancy); end
        n = 0;
        for (int i = 0; i < 6; i++) begin
            step();
            if (out_valid === 1'b1 && n < 4) begin seen[n] = out_data; n++; end
        end
        checks++; if (n !== 1 || seen[0] !== 32'h61) begin failures++; $display("[TB] FAIL holdflush_drain got n=%0d d=%h want n=1 d=61", n, seen[0]); end
        checks++; if (retired !== 32'd16) begin failures++; $display("[TB] FAIL holdflush_retired got %0d want 16", retired); end
    endtask

    task automatic test_retired_wrap_and_reset();
        force dut.retired_q = 32'hFFFF_FFFF;
        #1;
        release dut.retired_q;
        #1;
        checks++; if (retired !== 32'hFFFF_FFFF) begin failures++; $display("[TB] FAIL wrap_preload got %h want ffffffff", retired); end
        out_ready = 1'b1; in_valid = 1'b1; in_data = 32'h71; step();
        in_valid = 1'b0;
        for (int i = 0; i < 6; i++) step();
        checks++; if (retired !== 32'd0 || occupancy !== 3'd0) begin failures++; $display("[TB] FAIL wrap_result got ret=%h occ=%0d want ret=0 occ=0", retired, occupancy); end
        out_ready = 1'b0; in_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            in_data = 32'h80 + 32'(i);
            step();
        end
        checks++; if (out_valid !== 1'b1 || occupancy !== 3'd4) begin failures++; $display("[TB] FAIL midrst_pre got v=%b occ=%0d want v=1 occ=4", out_valid, occupancy); end
        out_ready = 1'b1; rst = 1'b1;
        #1;
        checks++; if (out_valid !== 1'b0 || in_ready !== 1'b0) begin failures++; $display("[TB] FAIL midrst_outputs got v=%b r=%b want v=0 r=0", out_valid, in_ready); end
        checks++; if (occupancy !== 3'd0 || retired !== 32'd0) begin failures++; $display("[TB] FAIL midrst_counts got occ=%0d ret=%0d want 0 0", occupancy, retired); end
        step();
        rst = 1'b0; in_valid = 1'b0;
        #1;
        checks++; if (in_ready !== 1'b1 || out_valid !== 1'b0 || retired !== 32'd0) begin failures++; $display("[TB] FAIL midrst_release got r=%b v=%b ret=%0d want r=1 v=0 ret=0", in_ready, out_valid, retired); end
    endtask

    initial begin
        test_reset();
        test_stream();
        test_full_throughput();
        test_bubble_collapse();
        test_flush();
        test_hold();
        test_retired_wrap_and_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
